// File: rtl/moore_pattern_tx.sv
// Serial pattern transmitter: shifts a captured WIDTH-bit pattern out MSB-first,
// repeated repeat_in+1 times with a one-cycle gap between frames.
module moore_pattern_tx #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern_in,
    input  logic [CNT_W-1:0] repeat_in,
    output logic             Data_out,
    output logic             bit_valid,
    output logic             busy,
    output logic             done,
    output logic             ready
);

    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, GAP, DONE} state_t;

    state_t           state, next_state;
    logic [WIDTH-1:0] pat_reg;
    logic [WIDTH-1:0] shift_reg;
    logic [CNT_W-1:0] rep_reg;
    logic [CNT_W-1:0] frm_cnt;
    logic [BW-1:0]    bit_cnt;
    logic             last_bit;
    logic             last_frame;

    assign last_bit   = (bit_cnt == BW'(WIDTH - 1));
    // Comparing before incrementing keeps frm_cnt from ever wrapping.
    assign last_frame = (frm_cnt == rep_reg);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (start) next_state = SHIFT;
            SHIFT:   if (last_bit) next_state = last_frame ? DONE : GAP;
            GAP:     next_state = SHIFT;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pat_reg   <= '0;
            shift_reg <= '0;
            rep_reg   <= '0;
            frm_cnt   <= '0;
            bit_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pat_reg   <= pattern_in;
                        shift_reg <= pattern_in;
                        rep_reg   <= repeat_in;
                        frm_cnt   <= '0;
                        bit_cnt   <= '0;
                    end
                end
                SHIFT: begin
                    if (last_bit && !last_frame) begin
                        // Reload during the gap so the next frame starts with its MSB.
                        shift_reg <= pat_reg;
                        bit_cnt   <= '0;
                        frm_cnt   <= frm_cnt + CNT_W'(1);
                    end else if (last_bit) begin
                        shift_reg <= shift_reg << 1;
                        bit_cnt   <= '0;
                    end else begin
                        shift_reg <= shift_reg << 1;
                        bit_cnt   <= bit_cnt + BW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        Data_out  = 1'b0;
        bit_valid = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        ready     = 1'b0;
        case (state)
            IDLE:  ready = 1'b1;
            SHIFT: begin
                Data_out  = shift_reg[WIDTH-1];
                bit_valid = 1'b1;
                busy      = 1'b1;
            end
            GAP:   busy = 1'b1;
            DONE:  done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_moore_pattern_tx.sv
// Bench for moore_pattern_tx: table-driven commands plus random commands, each
// compared cycle by cycle against a frame-list reference model.
module tb_moore_pattern_tx;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             start = 1'b0;
    logic [WIDTH-1:0] pattern_in = '0;
    logic [CNT_W-1:0] repeat_in = '0;
    logic             Data_out;
    logic             bit_valid;
    logic             busy;
    logic             done;
    logic             ready;

    int checks = 0;
    int failures = 0;

    // Expected per-cycle outputs packed as {Data_out, bit_valid, busy, done, ready}.
    logic [4:0] exp_q[$];

    typedef struct {
        logic [WIDTH-1:0] pat;
        logic [CNT_W-1:0] rep;
        bit               hold;
        int               inject_at;
        int               exp_busy;
    } vec_t;

    vec_t vecs[5];

    moore_pattern_tx #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pattern_in (pattern_in),
        .repeat_in  (repeat_in),
        .Data_out   (Data_out),
        .bit_valid  (bit_valid),
        .busy       (busy),
        .done       (done),
        .ready      (ready)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] observe();
        return {Data_out, bit_valid, busy, done, ready};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual != expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0b, expected %0b", name, actual, expected);
        end
    endtask

    // Reference model: R+1 copies of the pattern MSB-first, a gap after every frame
    // but the last, then one done cycle and one idle cycle.
    task automatic buildExpected(input logic [WIDTH-1:0] pat, input int rep);
        exp_q.delete();
        for (int f = 0; f <= rep; f++) begin
            for (int i = WIDTH - 1; i >= 0; i--)
                exp_q.push_back({pat[i], 1'b1, 1'b1, 1'b0, 1'b0});
            if (f < rep)
                exp_q.push_back(5'b00100);
        end
        exp_q.push_back(5'b00010);
        exp_q.push_back(5'b00001);
    endtask

    task automatic applyStimulus(input logic [WIDTH-1:0] pat, input logic [CNT_W-1:0] rep,
                                 input bit hold, input int inject_at, input int exp_busy,
                                 input string tag);
        int busy_cnt;
        busy_cnt   = 0;
        pattern_in = pat;
        repeat_in  = rep;
        start      = 1'b1;
        buildExpected(pat, int'(rep));
        for (int i = 0; i < exp_q.size(); i++) begin
            tick();
            checkOutput($sformatf("%s cyc%0d", tag, i), int'(observe()), int'(exp_q[i]));
            if (busy) busy_cnt++;
            pattern_in = WIDTH'($urandom);
            repeat_in  = CNT_W'($urandom);
            start      = hold || (i == inject_at);
            if (i == inject_at) pattern_in = 8'hFF;
        end
        checkOutput($sformatf("%s busy_cycles", tag), busy_cnt, exp_busy);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vecs[0] = '{pat: 8'hA6, rep: 4'd0, hold: 1'b0, inject_at: -1, exp_busy: 8};
        vecs[1] = '{pat: 8'h05, rep: 4'd2, hold: 1'b0, inject_at: -1, exp_busy: 26};
        vecs[2] = '{pat: 8'hA6, rep: 4'd0, hold: 1'b0, inject_at: 3,  exp_busy: 8};
        vecs[3] = '{pat: 8'h6C, rep: 4'd0, hold: 1'b1, inject_at: -1, exp_busy: 8};
        vecs[4] = '{pat: 8'h6C, rep: 4'd0, hold: 1'b0, inject_at: -1, exp_busy: 8};

        // Held reset, then release between edges; the block must sit idle.
        #1;
        checkOutput("reset async", int'(observe()), 5'b00001);
        for (int i = 0; i < 2; i++) begin
            tick();
            checkOutput($sformatf("reset hold %0d", i), int'(observe()), 5'b00001);
        end
        #2 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput($sformatf("idle after reset %0d", i), int'(observe()), 5'b00001);
        end

        for (int v = 0; v < 5; v++)
            applyStimulus(vecs[v].pat, vecs[v].rep, vecs[v].hold, vecs[v].inject_at,
                          vecs[v].exp_busy, $sformatf("vec%0d", v));

        // Abort during frame 2 of a four-frame command with an asynchronous reset.
        pattern_in = 8'h3C;
        repeat_in  = 4'd3;
        start      = 1'b1;
        buildExpected(8'h3C, 3);
        for (int i = 0; i < WIDTH + 1 + 3; i++) begin
            tick();
            checkOutput($sformatf("abort cyc%0d", i), int'(observe()), int'(exp_q[i]));
            start = 1'b0;
        end
        #2 rst = 1'b0;
        #1;
        checkOutput("abort async reset", int'(observe()), 5'b00001);
        for (int i = 0; i < 2; i++) begin
            tick();
            checkOutput($sformatf("abort no done %0d", i), int'(observe()), 5'b00001);
        end
        #2 rst = 1'b1;
        tick();
        checkOutput("abort idle", int'(observe()), 5'b00001);
        applyStimulus(8'hA6, 4'd0, 1'b0, -1, 8, "after abort");

        for (int r = 0; r < 12; r++) begin
            logic [WIDTH-1:0] pat;
            logic [CNT_W-1:0] rep;
            pat = WIDTH'($urandom);
            rep = CNT_W'($urandom_range(0, 5));
            applyStimulus(pat, rep, 1'b0, -1, WIDTH * (int'(rep) + 1) + int'(rep),
                          $sformatf("rand%0d", r));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
